carrier_loop_filter: RTL and testbench

//  PI loop filter for QAM16 carrier recovery. Sits directly downstream of the polarity phase detector.

---
 rtl/qam16_pkg.sv | 33 +++
 rtl/lf_lock_det.sv | 61 ++++++
 rtl/carrier_loop_filter.sv | 164 ++++++++++++++++
 tb/tb_carrier_loop_filter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam16_pkg.sv
// Shared definitions for the QAM16 carrier-recovery blocks: default widths,
// loop-filter FSM encoding and the symmetric saturation helper.
package qam16_pkg;

  localparam int unsigned PD_W_DEF  = 27;
  localparam int unsigned OUT_W_DEF = 32;

  // Working width of the saturation helper; every caller's sum must fit in it.
  localparam int unsigned SAT_W = 64;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StUpd  = 2'd2
  } lf_state_e;

  // Clamp v to +/-(2^(w-1)-1). The range is symmetric so negating a clamped
  // value can never overflow downstream.
  function automatic logic signed [SAT_W-1:0] sat_sym(input logic signed [SAT_W-1:0] v,
                                                      input int unsigned              w);
    logic signed [SAT_W-1:0] lim;
    logic signed [SAT_W-1:0] res;
    lim = (64'sd1 <<< (w - 1)) - 64'sd1;
    res = v;
    if (v > lim) begin
      res = lim;
    end else if (v < -lim) begin
      res = -lim;
    end
    return res;
  endfunction

endpackage

// File: rtl/lf_lock_det.sv
// Carrier lock detector: counts consecutive loop updates whose averaged error
// magnitude is under threshold and raises locked once enough have been seen.
module lf_lock_det
  import qam16_pkg::*;
#(
  parameter int unsigned PD_W     = PD_W_DEF,
  parameter int unsigned LOCK_THR = 64,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   upd,
  input  logic signed [PD_W-1:0] err,
  output logic                   locked
);

  localparam int unsigned CNT_W = $clog2(LOCK_CNT + 1);

  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;
  logic [PD_W:0]    err_abs;
  logic             in_lock;

  // Magnitude carries one spare bit so the most negative error cannot wrap.
  always_comb begin
    err_abs = err[PD_W-1] ? -{err[PD_W-1], err} : {err[PD_W-1], err};
    in_lock = (err_abs < (PD_W + 1)'(LOCK_THR));
  end

  // Saturating in-lock run counter; one out-of-range update drops lock at once.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (upd) begin
      if (in_lock) begin
        if (lock_cnt_q < CNT_W'(LOCK_CNT)) begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
        locked_d = (lock_cnt_d >= CNT_W'(LOCK_CNT));
      end else begin
        lock_cnt_d = '0;
        locked_d   = 1'b0;
      end
    end
  end

  // Lock state registers; clr behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign locked = locked_q;

endmodule

// File: rtl/carrier_loop_filter.sv
// PI loop filter for QAM16 carrier recovery. Integrates-and-dumps blocks of
// 2^DEC_LOG2 phase-error samples, then updates a saturating integrator and the
// NCO frequency word, and tracks carrier lock.
module carrier_loop_filter
  import qam16_pkg::*;
#(
  parameter int unsigned PD_W     = PD_W_DEF,
  parameter int unsigned OUT_W    = OUT_W_DEF,
  parameter int unsigned DEC_LOG2 = 3,
  parameter int unsigned K1_SH    = 4,
  parameter int unsigned K2_SH    = 10,
  parameter int unsigned LOCK_THR = 64,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic signed [PD_W-1:0]  pd,
  input  logic                    pd_vld,
  output logic signed [OUT_W-1:0] freq,
  output logic                    freq_vld,
  output logic signed [PD_W-1:0]  err,
  output logic                    locked
);

  localparam int unsigned N     = 1 << DEC_LOG2;
  localparam int unsigned ACC_W = PD_W + DEC_LOG2;
  // Two guard bits over the wider operand: the PI sums can never wrap before saturation.
  localparam int unsigned SUM_W = ((OUT_W > PD_W) ? OUT_W : PD_W) + 2;
  localparam logic [DEC_LOG2-1:0] CNT_LAST = DEC_LOG2'(N - 1);

  lf_state_e               state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [DEC_LOG2-1:0]     cnt_q, cnt_d;
  logic signed [OUT_W-1:0] integ_q, integ_d;
  logic signed [OUT_W-1:0] freq_q, freq_d;
  logic signed [PD_W-1:0]  err_q, err_d;
  logic                    freq_vld_q, freq_vld_d;
  logic                    upd;

  logic signed [ACC_W-1:0] pd_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [PD_W-1:0]  acc_avg;
  logic signed [PD_W-1:0]  err_k1, err_k2;
  logic signed [SUM_W-1:0] integ_sum, freq_sum;
  logic signed [OUT_W-1:0] integ_n, freq_n;

  // Integrate-and-dump datapath; the accumulator is wide enough for a full block.
  always_comb begin
    pd_ext  = ACC_W'(pd);
    acc_sum = acc_q + pd_ext;
    acc_avg = PD_W'(acc_sum >>> DEC_LOG2);
  end

  // PI arithmetic on the latched block average; proportional path uses the new integrator.
  always_comb begin
    err_k1    = err_q >>> K1_SH;
    err_k2    = err_q >>> K2_SH;
    integ_sum = SUM_W'(integ_q) + SUM_W'(err_k2);
    integ_n   = OUT_W'(sat_sym(SAT_W'(integ_sum), OUT_W));
    freq_sum  = SUM_W'(integ_n) + SUM_W'(err_k1);
    freq_n    = OUT_W'(sat_sym(SAT_W'(freq_sum), OUT_W));
  end

  // Loop FSM: gather a block, spend one cycle updating, never drop a sample.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    integ_d    = integ_q;
    freq_d     = freq_q;
    err_d      = err_q;
    freq_vld_d = 1'b0;
    upd        = 1'b0;
    unique case (state_q)
      StIdle: begin
        acc_d = '0;
        cnt_d = '0;
        if (en) begin
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (!en) begin
          // Partial block is thrown away.
          state_d = StIdle;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (pd_vld) begin
          if (cnt_q == CNT_LAST) begin
            err_d   = acc_avg;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StUpd;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + DEC_LOG2'(1);
          end
        end
      end
      StUpd: begin
        upd        = 1'b1;
        integ_d    = integ_n;
        freq_d     = freq_n;
        freq_vld_d = 1'b1;
        if (!en) begin
          state_d = StIdle;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          // A sample arriving now opens the next block.
          state_d = StAcc;
          acc_d   = pd_vld ? pd_ext : '0;
          cnt_d   = pd_vld ? DEC_LOG2'(1) : '0;
        end
      end
      default: begin
        state_d = StIdle;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; clr restarts acquisition with the same state as reset.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      cnt_q      <= '0;
      integ_q    <= '0;
      freq_q     <= '0;
      err_q      <= '0;
      freq_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      integ_q    <= integ_d;
      freq_q     <= freq_d;
      err_q      <= err_d;
      freq_vld_q <= freq_vld_d;
    end
  end

  lf_lock_det #(
    .PD_W     (PD_W),
    .LOCK_THR (LOCK_THR),
    .LOCK_CNT (LOCK_CNT)
  ) u_lock_det (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .upd    (upd),
    .err    (err_q),
    .locked (locked)
  );

  assign freq     = freq_q;
  assign freq_vld = freq_vld_q;
  assign err      = err_q;

endmodule

// File: tb/tb_carrier_loop_filter.sv
// Self-checking bench for carrier_loop_filter: a default 32-bit instance and a
// 20-bit instance share the same stimulus; a block-level model predicts both.
module tb_carrier_loop_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, en, clr, pd_vld;
  logic signed [26:0]  pd;
  logic signed [31:0]  freq;
  logic signed [19:0]  freq_w;
  logic signed [26:0]  err, err_w;
  logic                freq_vld, freq_vld_w, locked, locked_w;

  int n_tests = 0;
  int n_fail  = 0;

  // Block-level reference model state.
  longint mq[$];
  longint m_integ[2];
  longint m_freq[2];
  longint m_err;
  int     m_lockc;
  bit     m_locked, m_fire, m_idle, m_exp_vld;

  carrier_loop_filter dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .pd(pd), .pd_vld(pd_vld),
    .freq(freq), .freq_vld(freq_vld), .err(err), .locked(locked)
  );

  carrier_loop_filter #(.OUT_W(20)) dut_w (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .pd(pd), .pd_vld(pd_vld),
    .freq(freq_w), .freq_vld(freq_vld_w), .err(err_w), .locked(locked_w)
  );

  function automatic longint clampw(longint v, int w);
    longint lim;
    lim = (64'sd1 <<< (w - 1)) - 1;
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  task automatic model_reset;
    mq.delete();
    for (int i = 0; i < 2; i++) begin
      m_integ[i] = 0;
      m_freq[i]  = 0;
    end
    m_err = 0; m_lockc = 0; m_locked = 0; m_fire = 0; m_idle = 1;
  endtask

  task automatic apply_update;
    longint mag;
    for (int i = 0; i < 2; i++) begin
      int w;
      w = (i == 0) ? 32 : 20;
      m_integ[i] = clampw(m_integ[i] + (m_err >>> 10), w);
      m_freq[i]  = clampw(m_integ[i] + (m_err >>> 4), w);
    end
    mag = (m_err < 0) ? -m_err : m_err;
    if (mag < 64) begin
      if (m_lockc < 4) m_lockc++;
      m_locked = (m_lockc >= 4);
    end else begin
      m_lockc  = 0;
      m_locked = 0;
    end
  endtask

  // Drive one cycle, then advance the model to what the outputs show after the edge.
  task automatic step(input logic v_rst, input logic v_en, input logic v_clr,
                      input logic v_vld, input logic signed [26:0] v_pd);
    longint s;
    rst = v_rst; en = v_en; clr = v_clr; pd_vld = v_vld; pd = v_pd;
    @(posedge clk);
    #1;
    m_exp_vld = 0;
    if (!v_rst || v_clr) begin
      model_reset();
    end else begin
      if (m_fire) begin
        m_exp_vld = 1;
        apply_update();
        m_fire = 0;
      end
      if (!v_en) begin
        mq.delete();
        m_idle = 1;
      end else if (m_idle) begin
        m_idle = 0;
      end else if (v_vld) begin
        mq.push_back(longint'(v_pd));
        if (mq.size() == 8) begin
          s = 0;
          foreach (mq[i]) s += mq[i];
          m_err = s >>> 3;
          mq.delete();
          m_fire = 1;
        end
      end
    end
  endtask

  task automatic restart;
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
  endtask

  task automatic feed(input int n, input logic signed [26:0] v);
    repeat (n) step(1, 1, 0, 1, v);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++)
      step(0, 1'($urandom), 1'($urandom), 1'($urandom), 27'($urandom));
    n_tests += 7;
    if (freq !== 32'sd0) begin n_fail++; $display("FAIL reset_freq got %0d want 0", freq); end
    if (freq_w !== 20'sd0) begin n_fail++; $display("FAIL reset_freq_w got %0d want 0", freq_w); end
    if (err !== 27'sd0) begin n_fail++; $display("FAIL reset_err got %0d want 0", err); end
    if (freq_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", freq_vld); end
    if (freq_vld_w !== 1'b0) begin n_fail++; $display("FAIL reset_vld_w got %b want 0", freq_vld_w); end
    if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b want 0", locked); end
    if (locked_w !== 1'b0) begin n_fail++; $display("FAIL reset_locked_w got %b want 0", locked_w); end
  endtask

  task automatic test_pos_block;
    restart();
    feed(8, 27'sd1024);
    n_tests += 2;
    if (freq_vld !== 1'b0) begin n_fail++; $display("FAIL pos_early_vld got %b want 0", freq_vld); end
    if (err !== 27'sd1024) begin n_fail++; $display("FAIL pos_err got %0d want 1024", err); end
    step(1, 1, 0, 0, 0);
    n_tests += 4;
    if (freq_vld !== 1'b1) begin n_fail++; $display("FAIL pos_vld got %b want 1", freq_vld); end
    if (freq !== 32'sd65) begin n_fail++; $display("FAIL pos_freq got %0d want 65", freq); end
    if (freq_w !== 20'sd65) begin n_fail++; $display("FAIL pos_freq_w got %0d want 65", freq_w); end
    if (dut.integ_q !== 32'sd1) begin n_fail++; $display("FAIL pos_integ got %0d want 1", dut.integ_q); end
    step(1, 1, 0, 0, 0);
    n_tests += 2;
    if (freq_vld !== 1'b0) begin n_fail++; $display("FAIL pos_pulse got %b want 0", freq_vld); end
    if (freq !== 32'sd65) begin n_fail++; $display("FAIL pos_hold got %0d want 65", freq); end
    feed(8, 27'sd1024);
    step(1, 1, 0, 0, 0);
    n_tests += 2;
    if (freq_vld !== 1'b1) begin n_fail++; $display("FAIL pos2_vld got %b want 1", freq_vld); end
    if (freq !== 32'sd66) begin n_fail++; $display("FAIL pos2_freq got %0d want 66", freq); end
  endtask

  task automatic test_neg_block;
    restart();
    feed(8, -27'sd1024);
    step(1, 1, 0, 0, 0);
    n_tests += 4;
    if (err !== -27'sd1024) begin n_fail++; $display("FAIL neg_err got %0d want -1024", err); end
    if (freq !== -32'sd65) begin n_fail++; $display("FAIL neg_freq got %0d want -65", freq); end
    if (freq_w !== -20'sd65) begin n_fail++; $display("FAIL neg_freq_w got %0d want -65", freq_w); end
    if (freq_vld !== 1'b1) begin n_fail++; $display("FAIL neg_vld got %b want 1", freq_vld); end
  endtask

  task automatic test_saturation;
    int     k, nv;
    longint ei;
    logic signed [19:0] ei20;
    logic signed [31:0] ef32;
    k = 0; nv = 0;
    restart();
    for (int i = 0; i <= 80; i++) begin
      step(1, 1, 0, (i < 80), 27'sh3FFFFFF);
      nv += int'(freq_vld_w);
      if (m_exp_vld) begin
        k++;
        ei   = (65535 * longint'(k) > 524287) ? 524287 : 65535 * longint'(k);
        ei20 = ei[19:0];
        ei   = 65535 * longint'(k) + 4194303;
        ef32 = ei[31:0];
        n_tests += 3;
        if (dut_w.integ_q !== ei20) begin
          n_fail++; $display("FAIL sat_integ upd %0d got %0d want %0d", k, dut_w.integ_q, ei20);
        end
        if (freq_w !== 20'sd524287) begin
          n_fail++; $display("FAIL sat_freq_w upd %0d got %0d want 524287", k, freq_w);
        end
        if (freq !== ef32) begin
          n_fail++; $display("FAIL sat_freq32 upd %0d got %0d want %0d", k, freq, ef32);
        end
      end
    end
    n_tests++;
    if (nv != 10) begin n_fail++; $display("FAIL sat_pulses got %0d want 10", nv); end
  endtask

  task automatic test_lock;
    restart();
    for (int b = 1; b <= 4; b++) begin
      feed(8, 27'sd10);
      step(1, 1, 0, 0, 0);
      n_tests += 2;
      if (locked !== (b == 4)) begin
        n_fail++; $display("FAIL lock_rise blk %0d got %b want %b", b, locked, (b == 4));
      end
      if (locked_w !== (b == 4)) begin
        n_fail++; $display("FAIL lock_rise_w blk %0d got %b want %b", b, locked_w, (b == 4));
      end
    end
    feed(8, 27'sd1000);
    n_tests++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_hold got %b want 1", locked); end
    step(1, 1, 0, 0, 0);
    n_tests += 2;
    if (freq_vld !== 1'b1) begin n_fail++; $display("FAIL lock_fall_vld got %b want 1", freq_vld); end
    if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_fall got %b want 0", locked); end
  endtask

  task automatic test_en_clr;
    restart();
    for (int b = 0; b < 4; b++) begin
      feed(8, -27'sd40);
      step(1, 1, 0, 0, 0);
    end
    n_tests += 3;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL enc_locked got %b want 1", locked); end
    if (freq !== -32'sd7) begin n_fail++; $display("FAIL enc_freq got %0d want -7", freq); end
    if (dut.integ_q !== -32'sd4) begin n_fail++; $display("FAIL enc_integ got %0d want -4", dut.integ_q); end
    feed(5, -27'sd40);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 1, -27'sd40);
      n_tests += 3;
      if (freq_vld !== 1'b0) begin n_fail++; $display("FAIL frz_vld cyc %0d got %b want 0", i, freq_vld); end
      if (freq !== -32'sd7) begin n_fail++; $display("FAIL frz_freq cyc %0d got %0d want -7", i, freq); end
      if (locked !== 1'b1) begin n_fail++; $display("FAIL frz_locked cyc %0d got %b want 1", i, locked); end
    end
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 1, -27'sd40);
      n_tests++;
      if (freq_vld !== 1'b0) begin n_fail++; $display("FAIL fresh_vld smp %0d got %b want 0", i, freq_vld); end
    end
    step(1, 1, 0, 0, 0);
    n_tests += 2;
    if (freq_vld !== 1'b1) begin n_fail++; $display("FAIL fresh_upd got %b want 1", freq_vld); end
    if (freq !== -32'sd8) begin n_fail++; $display("FAIL fresh_freq got %0d want -8", freq); end
    feed(3, -27'sd40);
    step(1, 1, 1, 1, -27'sd40);
    n_tests += 5;
    if (freq !== 32'sd0) begin n_fail++; $display("FAIL clr_freq got %0d want 0", freq); end
    if (freq_w !== 20'sd0) begin n_fail++; $display("FAIL clr_freq_w got %0d want 0", freq_w); end
    if (dut.integ_q !== 32'sd0) begin n_fail++; $display("FAIL clr_integ got %0d want 0", dut.integ_q); end
    if (locked !== 1'b0) begin n_fail++; $display("FAIL clr_locked got %b want 0", locked); end
    if (err !== 27'sd0) begin n_fail++; $display("FAIL clr_err got %0d want 0", err); end
    step(1, 1, 0, 0, 0);
    feed(8, -27'sd40);
    step(1, 1, 0, 0, 0);
    feed(3, -27'sd40);
    step(0, 1, 0, 1, -27'sd40);
    n_tests += 4;
    if (freq !== 32'sd0) begin n_fail++; $display("FAIL rst_freq got %0d want 0", freq); end
    if (err !== 27'sd0) begin n_fail++; $display("FAIL rst_err got %0d want 0", err); end
    if (freq_vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld got %b want 0", freq_vld); end
    if (dut.integ_q !== 32'sd0) begin n_fail++; $display("FAIL rst_integ got %0d want 0", dut.integ_q); end
  endtask

  task automatic test_random;
    logic               r_en, r_clr, r_vld;
    logic signed [26:0] r_pd;
    logic signed [31:0] ef;
    logic signed [19:0] efw;
    logic signed [26:0] ee;
    restart();
    for (int i = 0; i < 400; i++) begin
      r_en  = ($urandom_range(0, 99) >= 3);
      r_clr = ($urandom_range(0, 199) == 0);
      r_vld = ($urandom_range(0, 9) < 7);
      if (((i / 64) % 2) == 0) r_pd = 27'(int'($urandom_range(0, 120)) - 60);
      else                     r_pd = 27'($urandom);
      step(1, r_en, r_clr, r_vld, r_pd);
      ef  = m_freq[0][31:0];
      efw = m_freq[1][19:0];
      ee  = m_err[26:0];
      n_tests += 7;
      if (freq_vld !== m_exp_vld) begin
        n_fail++; $display("FAIL rnd_vld cyc %0d got %b want %b", i, freq_vld, m_exp_vld);
      end
      if (freq_vld_w !== m_exp_vld) begin
        n_fail++; $display("FAIL rnd_vld_w cyc %0d got %b want %b", i, freq_vld_w, m_exp_vld);
      end
      if (freq !== ef) begin n_fail++; $display("FAIL rnd_freq cyc %0d got %0d want %0d", i, freq, ef); end
      if (freq_w !== efw) begin
        n_fail++; $display("FAIL rnd_freq_w cyc %0d got %0d want %0d", i, freq_w, efw);
      end
      if (err !== ee) begin n_fail++; $display("FAIL rnd_err cyc %0d got %0d want %0d", i, err, ee); end
      if (locked !== m_locked) begin
        n_fail++; $display("FAIL rnd_locked cyc %0d got %b want %b", i, locked, m_locked);
      end
      if (locked_w !== m_locked) begin
        n_fail++; $display("FAIL rnd_locked_w cyc %0d got %b want %b", i, locked_w, m_locked);
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; pd_vld = 1'b0; pd = '0;
    model_reset();
    test_reset();
    test_pos_block();
    test_neg_block();
    test_saturation();
    test_lock();
    test_en_clr();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
